// File: rtl/spi_norflash_responder.sv
// SPI NOR-flash target model (mode 0), oversampled on p_clk.
// Decodes WREN/WRDI/RDSR/READ/PP/CE against an internal byte array
// with NOR program semantics (bits only clear) and a timed chip erase.
module spi_norflash_responder #(
  parameter int ADDR_W = 8,
  parameter int PAGE_W = 4
) (
  input  logic p_clk,
  input  logic p_resetn,
  input  logic s_clk,
  input  logic s_css,
  input  logic s_mosi,
  output logic s_miso,
  output logic s_miso_oe,
  output logic wip,
  output logic wel
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_CE   = 8'hC7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RDATA,
    ST_PDATA,
    ST_STAT,
    ST_IGNORE
  } state_t;

  // Synchronizers and edge-detect history
  logic [1:0] r_sclk_sync;
  logic [1:0] r_css_sync;
  logic [1:0] r_mosi_sync;
  logic       r_sclk_prev;
  logic       r_css_prev;

  // Transaction state
  state_t            r_state;
  logic [2:0]        r_bitcnt;
  logic [6:0]        r_shift_in;
  logic [1:0]        r_abyte;
  logic              r_is_pp;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_shift_out;
  logic [2:0]        r_obit;
  logic              r_miso;
  logic              r_oe;

  // Deferred actions applied when chip select rises
  logic r_pend_set;
  logic r_pend_clr;
  logic r_pend_ce;

  // Status and erase engine
  logic              r_wel;
  logic              r_wip;
  logic [ADDR_W-1:0] r_erase_cnt;

  logic [7:0] r_mem [DEPTH];

  logic              w_sclk_rise;
  logic              w_sclk_fall;
  logic              w_css_rise;
  logic              w_css_fall;
  logic              w_mosi;
  logic [7:0]        w_byte;
  logic [7:0]        w_status;
  logic [ADDR_W-1:0] w_addr_next;

  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_prev;
  assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_prev;
  assign w_css_rise  = r_css_sync[1] & ~r_css_prev;
  assign w_css_fall  = ~r_css_sync[1] & r_css_prev;
  assign w_mosi      = r_mosi_sync[1];
  assign w_byte      = {r_shift_in, w_mosi};
  assign w_status    = {6'b0, r_wel, r_wip};
  assign w_addr_next = {r_addr[ADDR_W-2:0], w_mosi};

  assign s_miso    = r_miso;
  assign s_miso_oe = r_oe;
  assign wip       = r_wip;
  assign wel       = r_wel;

  // Two-flop synchronizers for the SPI pins plus one history stage for edges
  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      r_sclk_sync <= '0;
      r_css_sync  <= '1;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_css_prev  <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], s_clk};
      r_css_sync  <= {r_css_sync[0], s_css};
      r_mosi_sync <= {r_mosi_sync[0], s_mosi};
      r_sclk_prev <= r_sclk_sync[1];
      r_css_prev  <= r_css_sync[1];
    end
  end

  // Protocol FSM, array writes and erase engine share one block so every
  // array write port is arbitrated in one place (PP cannot run during erase)
  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      r_state     <= ST_IDLE;
      r_bitcnt    <= '0;
      r_shift_in  <= '0;
      r_abyte     <= '0;
      r_is_pp     <= 1'b0;
      r_addr      <= '0;
      r_shift_out <= '0;
      r_obit      <= '0;
      r_miso      <= 1'b0;
      r_oe        <= 1'b0;
      r_pend_set  <= 1'b0;
      r_pend_clr  <= 1'b0;
      r_pend_ce   <= 1'b0;
      r_wel       <= 1'b0;
      r_wip       <= 1'b0;
      r_erase_cnt <= '0;
      r_mem       <= '{default: 8'hFF};
    end else begin
      if (r_wip) begin
        r_mem[r_erase_cnt] <= 8'hFF;
        r_erase_cnt        <= r_erase_cnt + 1'b1;
        if (r_erase_cnt == '1) begin
          r_wip <= 1'b0;
        end
      end

      // Chip-select rise has priority over any clock edge seen in the same cycle
      if (w_css_rise) begin
        r_state  <= ST_IDLE;
        r_oe     <= 1'b0;
        r_miso   <= 1'b0;
        r_bitcnt <= '0;
        if (r_pend_set) begin
          r_wel <= 1'b1;
        end else if (r_pend_clr) begin
          r_wel <= 1'b0;
        end
        if (r_pend_ce && r_wel) begin
          r_wip       <= 1'b1;
          r_erase_cnt <= '0;
        end
        r_pend_set <= 1'b0;
        r_pend_clr <= 1'b0;
        r_pend_ce  <= 1'b0;
      end else if (w_css_fall) begin
        r_state    <= ST_CMD;
        r_bitcnt   <= '0;
        r_oe       <= 1'b0;
        r_pend_set <= 1'b0;
        r_pend_clr <= 1'b0;
        r_pend_ce  <= 1'b0;
      end else if (w_sclk_rise && (r_state != ST_IDLE)) begin
        r_bitcnt   <= r_bitcnt + 1'b1;
        r_shift_in <= w_byte[6:0];
        case (r_state)
          ST_CMD: begin
            if (r_bitcnt == 3'd7) begin
              if (r_wip && (w_byte != OP_RDSR)) begin
                r_state <= ST_IGNORE;
              end else begin
                case (w_byte)
                  OP_WREN: begin
                    r_pend_set <= 1'b1;
                    r_state    <= ST_IGNORE;
                  end
                  OP_WRDI: begin
                    r_pend_clr <= 1'b1;
                    r_state    <= ST_IGNORE;
                  end
                  OP_RDSR: begin
                    r_state     <= ST_STAT;
                    r_shift_out <= w_status;
                    r_obit      <= '0;
                    r_oe        <= 1'b1;
                  end
                  OP_READ: begin
                    r_state <= ST_ADDR;
                    r_is_pp <= 1'b0;
                    r_abyte <= '0;
                  end
                  OP_PP: begin
                    if (r_wel) begin
                      r_state    <= ST_ADDR;
                      r_is_pp    <= 1'b1;
                      r_abyte    <= '0;
                      r_pend_clr <= 1'b1;
                    end else begin
                      r_state <= ST_IGNORE;
                    end
                  end
                  OP_CE: begin
                    r_pend_ce  <= 1'b1;
                    r_pend_clr <= 1'b1;
                    r_state    <= ST_IGNORE;
                  end
                  default: r_state <= ST_IGNORE;
                endcase
              end
            end
          end
          ST_ADDR: begin
            // 24 address bits shift through; only the last ADDR_W survive
            if ((r_bitcnt == 3'd7) && (r_abyte == 2'd2)) begin
              if (r_is_pp) begin
                r_state <= ST_PDATA;
                r_addr  <= w_addr_next;
              end else begin
                r_state     <= ST_RDATA;
                r_shift_out <= r_mem[w_addr_next];
                r_addr      <= w_addr_next + 1'b1;
                r_obit      <= '0;
                r_oe        <= 1'b1;
              end
            end else begin
              r_addr <= w_addr_next;
              if (r_bitcnt == 3'd7) begin
                r_abyte <= r_abyte + 1'b1;
              end
            end
          end
          ST_PDATA: begin
            if (r_bitcnt == 3'd7) begin
              r_mem[r_addr] <= r_mem[r_addr] & w_byte;
              r_addr <= {r_addr[ADDR_W-1:PAGE_W], r_addr[PAGE_W-1:0] + 1'b1};
            end
          end
          default: ;
        endcase
      end else if (w_sclk_fall && ((r_state == ST_RDATA) || (r_state == ST_STAT))) begin
        r_miso <= r_shift_out[7];
        r_obit <= r_obit + 1'b1;
        // After the last bit of a byte goes out, queue up the next byte
        if (r_obit == 3'd7) begin
          if (r_state == ST_STAT) begin
            r_shift_out <= w_status;
          end else begin
            r_shift_out <= r_mem[r_addr];
            r_addr      <= r_addr + 1'b1;
          end
        end else begin
          r_shift_out <= {r_shift_out[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_norflash_responder.sv
// Directed bench for spi_norflash_responder with a transaction-level model.
module tb_spi_norflash_responder;

  localparam int HALF = 4;

  logic p_clk = 1'b0;
  logic p_resetn;
  logic s_clk;
  logic s_css;
  logic s_mosi;
  logic s_miso;
  logic s_miso_oe;
  logic wip;
  logic wel;

  spi_norflash_responder #(.ADDR_W(8), .PAGE_W(4)) dut (
    .p_clk     (p_clk),
    .p_resetn  (p_resetn),
    .s_clk     (s_clk),
    .s_css     (s_css),
    .s_mosi    (s_mosi),
    .s_miso    (s_miso),
    .s_miso_oe (s_miso_oe),
    .wip       (wip),
    .wel       (wel)
  );

  always #5 p_clk = ~p_clk;

  int cyc = 0;
  always @(posedge p_clk) cyc <= cyc + 1;

  int nchecks = 0;
  int nerr = 0;

  logic [7:0] tx [16];
  logic [7:0] rx [16];
  logic       rx_oe [16];
  int r8;
  int crise = 0;
  bit chk_en = 0;

  // Model state: array contents, WEL as old/new value with switch cycle,
  // WIP as a 256-cycle window starting 3 cycles after CE's chip-select rise.
  logic [7:0] mem_m [256];
  logic wel_old, wel_new;
  int   wel_chg;
  int   ws;

  function automatic logic wel_at(int c);
    return (c >= wel_chg) ? wel_new : wel_old;
  endfunction

  function automatic logic wip_at(int c);
    return (c >= ws) && (c < ws + 256);
  endfunction

  task automatic chk(string name, int act, int exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mem_m[i] = 8'hFF;
    wel_old = 1'b0;
    wel_new = 1'b0;
    wel_chg = 0;
    ws      = -100000;
  endtask

  task automatic set_wel(logic v);
    wel_old = wel_at(crise);
    wel_new = v;
    wel_chg = crise + 3;
  endtask

  // Apply the effect of a completed transaction (opcode decided at 8th rise)
  task automatic model_end(int n);
    logic [7:0] op;
    logic busy, we;
    int a;
    op   = tx[0];
    busy = wip_at(r8 + 2);
    we   = wel_at(r8 + 2);
    if (busy && op != 8'h05) return;
    case (op)
      8'h06: set_wel(1'b1);
      8'h04: set_wel(1'b0);
      8'h02: begin
        if (we) begin
          a = int'(tx[3]);
          for (int k = 4; k < n; k++) begin
            mem_m[a] = mem_m[a] & tx[k];
            a = (a & 32'hF0) | ((a + 1) & 32'h0F);
          end
        end
        set_wel(1'b0);
      end
      8'hC7: begin
        if (we) begin
          ws = crise + 3;
          for (int i = 0; i < 256; i++) mem_m[i] = 8'hFF;
        end
        set_wel(1'b0);
      end
      default: ;
    endcase
  endtask

  // Continuous comparison of status pins against the model
  always @(negedge p_clk) begin
    if (p_resetn && chk_en) begin
      chk("wel_track", int'(wel), int'(wel_at(cyc)));
      chk("wip_track", int'(wip), int'(wip_at(cyc)));
      if (s_css && cyc >= crise + 3) chk("oe_idle", int'(s_miso_oe), 0);
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge p_clk);
    #1;
  endtask

  task automatic spi_txn(int nbytes, int extra);
    int nb;
    int total;
    total = nbytes + ((extra > 0) ? 1 : 0);
    s_css = 1'b0;
    tick(HALF);
    for (int b = 0; b < total; b++) begin
      nb = (b < nbytes) ? 8 : extra;
      for (int i = 0; i < nb; i++) begin
        s_mosi = tx[b][7-i];
        tick(HALF);
        rx[b][7-i] = s_miso;
        if (i == 0) rx_oe[b] = s_miso_oe;
        s_clk = 1'b1;
        if (b == 0 && i == 7) r8 = cyc;
        tick(HALF);
        s_clk = 1'b0;
      end
    end
    tick(HALF);
    s_css = 1'b1;
    crise = cyc;
    if (nbytes > 0) model_end(nbytes);
    tick(6);
  endtask

  task automatic do_wren();
    tx[0] = 8'h06;
    spi_txn(1, 0);
  endtask

  task automatic do_read(int addr, int nd);
    tx[0] = 8'h03; tx[1] = 8'h00; tx[2] = 8'h00; tx[3] = addr[7:0];
    for (int k = 4; k < 4 + nd; k++) tx[k] = 8'h00;
    spi_txn(4 + nd, 0);
    if (wip_at(r8 + 2)) begin
      chk("rd_busy_oe", int'(rx_oe[4]), 0);
    end else begin
      for (int k = 4; k < 4 + nd; k++) begin
        chk("rd_oe", int'(rx_oe[k]), 1);
        chk("rd_data", int'(rx[k]), int'(mem_m[(addr + k - 4) & 255]));
      end
    end
  endtask

  task automatic do_rdsr();
    tx[0] = 8'h05; tx[1] = 8'h00;
    spi_txn(2, 0);
    chk("sr_oe", int'(rx_oe[1]), 1);
    chk("sr_data", int'(rx[1]), int'({6'b0, wel_at(r8 + 2), wip_at(r8 + 2)}));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    s_clk = 1'b0; s_css = 1'b1; s_mosi = 1'b0; p_resetn = 1'b0;
    model_reset();
    tick(3);
    p_resetn = 1'b1;
    tick(2);
    chk("rst_miso", int'(s_miso), 0);
    chk("rst_oe", int'(s_miso_oe), 0);
    chk("rst_wel", int'(wel), 0);
    chk("rst_wip", int'(wip), 0);
    chk_en = 1;

    // WREN, PP 0x10 <- A5,3C, read back, status
    do_wren();
    chk("wel_after_wren", int'(wel), 1);
    tx[0] = 8'h02; tx[1] = 8'h00; tx[2] = 8'h00; tx[3] = 8'h10; tx[4] = 8'hA5; tx[5] = 8'h3C;
    spi_txn(6, 0);
    do_read(8'h10, 2);
    chk("lit_rd_A5", int'(rx[4]), 8'hA5);
    chk("lit_rd_3C", int'(rx[5]), 8'h3C);
    do_rdsr();
    chk("lit_sr_00", int'(rx[1]), 8'h00);

    // PP without WREN is ignored
    tx[0] = 8'h02; tx[1] = 8'h00; tx[2] = 8'h00; tx[3] = 8'h20; tx[4] = 8'h00;
    spi_txn(5, 0);
    do_read(8'h20, 1);
    chk("lit_nowel_FF", int'(rx[4]), 8'hFF);

    // AND semantics
    do_wren();
    tx[0] = 8'h02; tx[1] = 8'h00; tx[2] = 8'h00; tx[3] = 8'h30; tx[4] = 8'hF0;
    spi_txn(5, 0);
    do_wren();
    tx[0] = 8'h02; tx[1] = 8'h00; tx[2] = 8'h00; tx[3] = 8'h30; tx[4] = 8'h3F;
    spi_txn(5, 0);
    do_read(8'h30, 1);
    chk("lit_and_30", int'(rx[4]), 8'h30);

    // Page wrap
    do_wren();
    tx[0] = 8'h02; tx[1] = 8'h00; tx[2] = 8'h00; tx[3] = 8'h0E;
    tx[4] = 8'h11; tx[5] = 8'h22; tx[6] = 8'h33; tx[7] = 8'h44;
    spi_txn(8, 0);
    do_read(8'h0E, 2);
    chk("lit_wrap_11", int'(rx[4]), 8'h11);
    chk("lit_wrap_22", int'(rx[5]), 8'h22);
    do_read(8'h00, 2);
    chk("lit_wrap_33", int'(rx[4]), 8'h33);
    chk("lit_wrap_44", int'(rx[5]), 8'h44);

    // Partial data byte is dropped; WEL still cleared
    do_wren();
    tx[0] = 8'h02; tx[1] = 8'h00; tx[2] = 8'h00; tx[3] = 8'h40; tx[4] = 8'h00;
    spi_txn(4, 5);
    do_read(8'h40, 1);
    chk("lit_partial_FF", int'(rx[4]), 8'hFF);
    chk("lit_partial_wel", int'(wel), 0);

    // Chip erase
    do_wren();
    tx[0] = 8'hC7;
    spi_txn(1, 0);
    chk("lit_ce_wip", int'(wip), 1);
    do_rdsr();
    chk("lit_sr_busy", int'(rx[1]), 8'h01);
    do_read(8'h10, 1);
    chk("lit_busy_oe", int'(rx_oe[4]), 0);
    for (int p = 0; p < 8 && wip_at(cyc); p++) do_rdsr();
    do_rdsr();
    chk("lit_sr_done", int'(rx[1]), 8'h00);
    do_read(8'h0E, 4);
    for (int k = 4; k < 8; k++) chk("lit_erased", int'(rx[k]), 8'hFF);

    // Reset in the middle of a READ data phase
    do_wren();
    for (int k = 0; k < 10; k++) tx[k] = 8'h00;
    tx[0] = 8'h03; tx[3] = 8'h10;
    fork
      spi_txn(10, 0);
      begin
        tick(300);
        chk("lit_oe_pre_rst", int'(s_miso_oe), 1);
        p_resetn = 1'b0;
        model_reset();
        #1;
        chk("lit_rst_oe", int'(s_miso_oe), 0);
        chk("lit_rst_wel", int'(wel), 0);
        chk("lit_rst_miso", int'(s_miso), 0);
        tick(2);
        p_resetn = 1'b1;
      end
    join
    do_read(8'h10, 2);
    chk("lit_rst_arr0", int'(rx[4]), 8'hFF);
    chk("lit_rst_arr1", int'(rx[5]), 8'hFF);

    tick(10);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/spi_norflash_responder.md
# spi_norflash_responder

SPI NOR-flash target that sits on the far end of the controller's serial pins (`s_clk`, `s_css`, `s_mosi`, `s_miso`) and stands in for the external flash device. It is synthesizable and runs on the system clock `p_clk`, oversampling the SPI lines. It decodes a byte-wide command set (write-enable, status read, read, page program, chip erase) against an internal byte array. It is the device-side counterpart used for loopback and in-system testing of the APB-to-SPI controller.

## Interface

Parameters:
- `ADDR_W`, 8: array address width; depth is 2^ADDR_W bytes.
- `PAGE_W`, 4: page-offset width; page size is 2^PAGE_W bytes.

Ports:
- `p_clk`, input, 1: system clock; all state is on its rising edge.
- `p_resetn`, input, 1: reset; one clock; reset is asynchronous and active-low.
- `s_clk`, input, 1: SPI serial clock, mode 0 (idle low).
- `s_css`, input, 1: chip select, active low.
- `s_mosi`, input, 1: serial data in, MSB first.
- `s_miso`, output, 1: serial data out, MSB first.
- `s_miso_oe`, output, 1: high while the block drives `s_miso` (read/status data phase).
- `wip`, output, 1: write-in-progress (erase running), mirrors status bit 0.
- `wel`, output, 1: write-enable latch, mirrors status bit 1.

## Operation

- `s_clk`, `s_css` and `s_mosi` pass through 2-flop synchronizers; edges of `s_clk` and `s_css` are detected on the synchronized copies. Requirement: `p_clk` ≥ 8× `s_clk`.
- Falling `s_css` starts a transaction: bit counter = 0, state CMD. Rising `s_css` ends it: state IDLE, `s_miso_oe` = 0, partial byte discarded.
- `s_mosi` is shifted in on each detected `s_clk` rise. A byte completes on the 8th rise.
- States: IDLE, CMD, ADDR (3 bytes, 24-bit address, low ADDR_W bits used), RDATA, PDATA, STAT, IGNORE.
- Opcodes, decoded at the end of the CMD byte:
  - 0x06 WREN: `wel` set when `s_css` rises.
  - 0x04 WRDI: `wel` cleared when `s_css` rises.
  - 0x05 RDSR: go to STAT; shift out status {6'b0, `wel`, `wip`} repeatedly until `s_css` rises.
  - 0x03 READ: ADDR then RDATA. Stream `mem[addr]`, then `addr`+1, wrapping at 2^ADDR_W.
  - 0x02 PP: ADDR then PDATA. Each completed data byte does `mem[addr] <= mem[addr] & byte` (NOR semantics: bits only go 1→0). The page offset (low PAGE_W bits) increments and wraps within the page; the page bits stay fixed. If `wel` = 0 at opcode time, go to IGNORE.
  - 0xC7 CE: at `s_css` rise with `wel` = 1, set `wip` and write 0xFF to one byte per `p_clk`, starting at address 0. When the last byte is written, clear `wip`.
  - Any other opcode: IGNORE until `s_css` rises.
- `wel` is cleared at the `s_css` rise that ends any PP transaction (WEL was 1) or any CE transaction.
- While `wip` = 1, every opcode except RDSR goes to IGNORE.
- Output shifting: on each detected `s_clk` fall in RDATA or STAT, drive the next bit. The first data bit is driven on the fall following the last address or opcode bit. After a full byte, load the next byte.

## Timing

- Reset values: `s_miso` = 0, `s_miso_oe` = 0, `wel` = 0, `wip` = 0, state IDLE, all array bytes 0xFF, erase counter 0.
- A reset asserted mid-transaction or mid-erase aborts immediately. The array returns to 0xFF.
- Edge-to-effect latency from an SPI pin edge is 3 `p_clk` (2 synchronizer stages + 1 registered action). `s_miso` is valid within 3 `p_clk` of `s_clk` falling.
- A program byte is written to the array 3 `p_clk` after the 8th `s_clk` rise of that byte.
- CE duration is 2^ADDR_W `p_clk`. `wip` rises 3 `p_clk` after `s_css` rises.
- If an `s_css` rise and an `s_clk` edge are detected in the same cycle, `s_css` wins and the clock edge is ignored.
- A falling `s_css` during erase starts a transaction normally; only RDSR is honoured.

## Test plan

- WREN, then PP at address 0x000010 with data 0xA5, 0x3C, then READ from 0x10 for 2 bytes → `s_miso` returns 0xA5, 0x3C; RDSR afterwards returns 0x00.
- PP without WREN at address 0x20 with data 0x00 → a read of 0x20 returns 0xFF.
- Two WREN+PP writes to the same byte, with 0xF0 then 0x3F → read returns 0x30 (AND semantics).
- WREN, PP at page offset 0xE (PAGE_W = 4) with 4 bytes 0x11, 0x22, 0x33, 0x44 → the array holds 0x11@0x0E, 0x22@0x0F, 0x33@0x00, 0x44@0x01.
- WREN, CE, then RDSR polled repeatedly → reads 0x01 (only status bit 0, `wip`, set — `wel` already cleared when CE's `s_css` rose) until 256 `p_clk` have elapsed, then 0x00. A READ issued during the erase returns `s_miso_oe` = 0; a READ afterwards returns 0xFF everywhere.
- `s_css` raised after 5 bits of a PP data byte → that byte is not written. `p_resetn` pulsed low mid-READ → `s_miso_oe` = 0 immediately and `wel` = 0.
